// File: rtl/dm_pkg.sv
// ============================================================================
// Module   : dm_pkg
// Purpose  : Shared types, lane masks and load alignment helpers for dm_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dm_pkg;

    typedef enum logic [2:0] {
        DM_BYTE_S = 3'b000,
        DM_HALF_S = 3'b001,
        DM_WORD   = 3'b010,
        DM_BYTE_U = 3'b100,
        DM_HALF_U = 3'b101
    } dm_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    localparam logic [3:0] c_MASK_BYTE = 4'b0001;
    localparam logic [3:0] c_MASK_HALF = 4'b0011;
    localparam logic [3:0] c_MASK_WORD = 4'b1111;

    function automatic logic dm_ctrl_legal(input logic [2:0] ctrl);
        case (ctrl)
            DM_BYTE_S, DM_HALF_S, DM_WORD, DM_BYTE_U, DM_HALF_U: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] dm_lane_mask(input logic [2:0] ctrl);
        case (ctrl[1:0])
            2'b00:   return c_MASK_BYTE;
            2'b01:   return c_MASK_HALF;
            default: return c_MASK_WORD;
        endcase
    endfunction

    // Snap the byte offset down to the natural boundary of the access size.
    function automatic logic [1:0] dm_align(input logic [1:0] offset, input logic [2:0] ctrl);
        case (ctrl[1:0])
            2'b00:   return offset;
            2'b01:   return {offset[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] dm_extend(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  ctrl);
        logic [31:0] w_sh;
        w_sh = word >> {offset, 3'b000};
        case (ctrl)
            DM_BYTE_S: return {{24{w_sh[7]}}, w_sh[7:0]};
            DM_HALF_S: return {{16{w_sh[15]}}, w_sh[15:0]};
            DM_WORD:   return w_sh;
            DM_BYTE_U: return {24'h0, w_sh[7:0]};
            DM_HALF_U: return {16'h0, w_sh[15:0]};
            default:   return 32'h0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_byte_ram.sv
// ============================================================================
// Module   : dm_byte_ram
// Purpose  : DEPTH_WORDS x 4-lane byte RAM, per-lane write enables, registered read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dm_byte_ram #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int c_IDX_W     = $clog2(DEPTH_WORDS)
) (
    input  logic               clk,
    input  logic [c_IDX_W-1:0] i_addr,
    input  logic               i_re,
    input  logic [3:0]         i_we,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH_WORDS];
            logic [7:0] r_q;

            // Read register only moves on a load so the response data stays put.
            always_ff @(posedge clk) begin
                if (i_we[gi]) r_mem[i_addr] <= i_wdata[8*gi +: 8];
                if (i_re)     r_q           <= r_mem[i_addr];
            end

            assign o_rdata[8*gi +: 8] = r_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/dm_ctrl.sv
// ============================================================================
// Module   : dm_ctrl
// Purpose  : Clocked byte-addressed data memory with valid/ready handshake.
//            Define DM_MISALIGN_TRAP_EN to report misaligned accesses as errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dm_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_LAT    = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         c_IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [1:0] c_LAT_INIT = 2'(READ_LAT - 1);

    dm_state_e   r_state;
    logic [1:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic        r_we;
    logic [1:0]  r_off;
    logic [2:0]  r_ctrl;

    logic        w_accept;
    logic        w_err;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ram_q;

    assign w_accept = req_valid & r_req_ready;

`ifdef DM_MISALIGN_TRAP_EN
    logic w_misal;
    assign w_misal = ((req_ctrl[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_ctrl[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_err   = !dm_ctrl_legal(req_ctrl) || w_misal;
    assign w_off   = req_addr[1:0];
`else
    assign w_err   = !dm_ctrl_legal(req_ctrl);
    assign w_off   = dm_align(req_addr[1:0], req_ctrl);
`endif

    // Whole store lands on the accept edge, so a reset can never split it.
    assign w_be    = (w_accept && req_we && !w_err) ? (dm_lane_mask(req_ctrl) << w_off) : 4'b0000;
    assign w_wdata = req_wdata << {w_off, 3'b000};

    generate
        if (ADDR_W > c_IDX_W + 2) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^req_addr[ADDR_W-1:c_IDX_W+2];
        end
    endgenerate

    dm_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_addr  (req_addr[c_IDX_W+1:2]),
        .i_re    (w_accept & ~req_we),
        .i_we    (w_be),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 2'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_we        <= 1'b0;
            r_off       <= 2'd0;
            r_ctrl      <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_off       <= w_off;
                        r_ctrl      <= req_ctrl;
                        r_rsp_err   <= w_err;
                        r_req_ready <= 1'b0;
                        if (req_we || READ_LAT == 1) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= c_LAT_INIT;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = (r_rsp_valid && !r_we && !r_rsp_err) ?
                       dm_extend(w_ram_q, r_off, r_ctrl) : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_dm_ctrl.sv
// ============================================================================
// Module   : tb_dm_ctrl
// Purpose  : Scoreboard bench for dm_ctrl against a byte-array memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dm_ctrl;

    localparam int c_DEPTH = 16;
    localparam int c_LAT   = 3;
    localparam int c_BYTES = c_DEPTH * 4;
`ifdef DM_MISALIGN_TRAP_EN
    localparam bit c_TRAP = 1'b1;
`else
    localparam bit c_TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_ctrl = 3'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dm_ctrl #(
        .DEPTH_WORDS (c_DEPTH),
        .READ_LAT    (c_LAT),
        .ADDR_W      (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl [c_BYTES];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned sz_of(input logic [2:0] c);
        return (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit legal(input logic [2:0] c);
        return (c == 3'b000) || (c == 3'b001) || (c == 3'b010) || (c == 3'b100) || (c == 3'b101);
    endfunction

    function automatic bit is_err(input logic [2:0] c, input logic [31:0] a);
        return !legal(c) || (c_TRAP && ((a % sz_of(c)) != 0));
    endfunction

    function automatic int unsigned base_of(input logic [2:0] c, input logic [31:0] a);
        int unsigned b;
        b = a % c_BYTES;
        return b - (b % sz_of(c));
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] c, input logic [31:0] a);
        logic [31:0] v;
        int unsigned b, sz;
        if (is_err(c, a)) return 32'h0;
        v  = 32'h0;
        sz = sz_of(c);
        b  = base_of(c, a);
        for (int i = 0; i < int'(sz); i++) v[8*i +: 8] = mdl[b + i];
        if (!c[2] && sz < 4 && v[8*sz-1])
            for (int i = 8 * sz; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_store(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        int unsigned b;
        if (is_err(c, a)) return;
        b = base_of(c, a);
        for (int i = 0; i < int'(sz_of(c)); i++) mdl[b + i] = d[8*i +: 8];
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] ctrl, input int stall, output logic [31:0] got);
        exp_t e;
        int   n;
        e.err   = is_err(ctrl, addr);
        e.rdata = (we || e.err) ? 32'h0 : model_load(ctrl, addr);
        sb.push_back(e);
        if (we) model_store(ctrl, addr, wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_ctrl = ctrl;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, we ? 32'd1 : 32'(c_LAT));
        for (int i = 0; i < stall; i++) begin
            chk("hold_rdata", rsp_rdata, sb[0].rdata);
            @(negedge clk);
            chk("hold_valid", {31'h0, rsp_valid}, 32'h1);
        end
        e = sb.pop_front();
        chk("rdata", rsp_rdata, e.rdata);
        chk("err", {31'h0, rsp_err}, {31'h0, e.err});
        got = rsp_rdata;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_ready", {31'h0, req_ready}, 32'h1);
        chk("idle_valid", {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        rst_n = 1'b1;

        for (int w = 0; w < c_DEPTH; w++) xact(1'b1, 32'(w * 4), $urandom, 3'b010, 0, got);

        xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, got);
        xact(1'b0, 32'h10, 32'h0, 3'b000, 0, got); chk("lb_signed", got, 32'hFFFFFFEF);
        xact(1'b0, 32'h10, 32'h0, 3'b100, 0, got); chk("lb_unsigned", got, 32'h000000EF);
        xact(1'b0, 32'h12, 32'h0, 3'b001, 0, got); chk("lh_signed", got, 32'hFFFFDEAD);
        xact(1'b0, 32'h12, 32'h0, 3'b101, 0, got); chk("lh_unsigned", got, 32'h0000DEAD);
        xact(1'b1, 32'h11, 32'h55, 3'b000, 0, got);
        xact(1'b0, 32'h10, 32'h0, 3'b010, 2, got); chk("byte_merge", got, 32'hDEAD55EF);

        xact(1'b1, 32'h20, 32'h12345678, 3'b011, 0, got);
        xact(1'b0, 32'h20, 32'h0, 3'b010, 0, got);
        xact(1'b0, 32'h22, 32'h0, 3'b010, 1, got);
        if (c_TRAP) chk("misal_trap", got, 32'h0);
        else        chk("misal_align", got, model_load(3'b010, 32'h20));

        xact(1'b1, 32'h50, 32'hCAFEF00D, 3'b010, 0, got);
        xact(1'b0, 32'h10, 32'h0, 3'b010, 0, got); chk("wrap", got, 32'hCAFEF00D);
        xact(1'b1, 32'h13, 32'h0000A5A5, 3'b001, 0, got);
        xact(1'b0, 32'h10, 32'h0, 3'b010, 0, got);

        // Reset while a load waits in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_ctrl = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        chk("wait_ready", {31'h0, req_ready}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rstw_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a committed store sits in RESP.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h77665544; req_ctrl = 3'b010;
        model_store(3'b010, 32'h30, 32'h77665544);
        @(negedge clk);
        req_valid = 1'b0;
        chk("resp_valid", {31'h0, rsp_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstr_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rstr_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, 32'h30, 32'h0, 3'b010, 0, got); chk("store_kept", got, 32'h77665544);

        for (int k = 0; k < 40; k++)
            xact(1'($urandom % 2), $urandom % 128, $urandom, 3'($urandom % 8), int'($urandom % 3), got);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Parametrised, clocked successor to the single-cycle data memory.
- Byte-addressed, little-endian data RAM behind a valid/ready request/response handshake.
- Supports byte, half and word loads/stores, sign or zero extension, configurable depth and read latency, and misalignment detection.
- Sits between the core load/store unit and the RAM array and replaces the combinational memory.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words. Power of two, at least 4.
- READ_LAT, 1: cycles from request acceptance to read response. Range 1..4.
- ADDR_W, 32: width of the byte address port. Upper bits beyond log2(DEPTH_WORDS)+2 are ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low bytes are used for sub-word stores.
- req_ctrl  in  3  size/extension code: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal ctrl code or misaligned access.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM state IDLE, latency counter 0. RAM contents are not reset.
- Asserting rst_n low mid-transaction returns the block to IDLE immediately and drops rsp_valid. A store already accepted is either fully written or not written at all; a partial byte write is never allowed.
- States and transitions:
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) captures the address, ctrl, we and wdata.
    - Store: goes to RESP.
    - Load: goes to RESP if READ_LAT=1, otherwise to WAIT with counter=READ_LAT-1.
  - WAIT: req_ready=0. The counter decrements each cycle; at 1 the state goes to RESP.
  - RESP: rsp_valid=1 with rsp_rdata/rsp_err held stable until rsp_ready. On rsp_ready the state returns to IDLE.
- Throughput and latency:
  - No request overlap. Minimum spacing is READ_LAT+1 cycles for loads and 2 cycles for stores.
  - Load latency is exactly READ_LAT cycles from the accept edge to rsp_valid high, assuming no backpressure.
- Store timing and enables:
  - The store is committed to RAM on the accept edge using byte enables.
  - Byte store: enables lane addr[1:0].
  - Half store: enables lanes {addr[1],0} and {addr[1],1}.
  - Word store: enables all four lanes.
  - Unselected lanes are unchanged.
- Load alignment and extension:
  - The word index is addr[log2(DEPTH)+1:2].
  - The selected byte or half is shifted to bit 0, then sign- or zero-extended according to req_ctrl.
- Read-after-write: a load accepted after a store's response returns the stored data.
- Illegal ctrl (011, 110, 111): no RAM write, rsp_err=1, rsp_rdata=0, normal response timing.
- Out-of-range address bits wrap modulo the depth; this is not an error.
- Misalignment (half with addr[0]=1, or word with addr[1:0]!=0) is handled per the optional feature below.
- While in RESP, req_valid is ignored. rsp_ready asserted while not in RESP has no effect.

Optional Feature:
- Macro: DM_MISALIGN_TRAP_EN.
- Defined: a misaligned access sets rsp_err=1, suppresses the write, and forces rsp_rdata=0.
- Undefined: the low address bits are forced to alignment (half: addr[0]=0; word: addr[1:0]=0), the access proceeds normally, and rsp_err reflects only illegal ctrl.

Decomposition:
- Package dm_pkg holds:
  - enum dm_size_e for the five ctrl codes;
  - enum dm_state_e {IDLE, WAIT, RESP};
  - constants for the lane masks;
  - a function dm_extend(word, offset, ctrl) for load alignment and extension.
- One sub-module, dm_byte_ram: a DEPTH_WORDS x 4-lane RAM with per-lane write enables and registered read. The FSM, counter and extension logic live in dm_ctrl.

Test Plan:
- After reset with no requests: req_ready=1, rsp_valid=0. Pull rst_n low during WAIT → rsp_valid=0 and req_ready=1 immediately.
- Store word 0xDEADBEEF to 0x10, then loads to 0x10:
  - ctrl 000 → 0xFFFFFFEF;
  - ctrl 100 → 0x000000EF;
  - ctrl 001 with addr 0x12 → 0xFFFFDEAD;
  - ctrl 101 with addr 0x12 → 0x0000DEAD.
- Store byte 0x55 to 0x11 over 0xDEADBEEF, then word load of 0x10 → 0xDEAD55EF.
- READ_LAT=3 with rsp_ready held low 2 cycles: rsp_valid rises exactly 3 cycles after accept and rsp_rdata stays stable until the rsp_ready handshake.
- ctrl 011 store of 0x12345678 to 0x20 → rsp_err=1, and a later word load of 0x20 returns the prior value unchanged.
- Word load at 0x22:
  - with DM_MISALIGN_TRAP_EN → rsp_err=1, rsp_rdata=0;
  - without it → rsp_err=0 and the word at 0x20 is returned.
